// File: rtl/complex_mac_stream_if.sv
// complex_mac_stream_if: AXI-stream style operand/result bundle for the complex MAC
interface complex_mac_stream_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16
);
  localparam int AP   = ((A_WIDTH + 7) / 8) * 8;
  localparam int BP   = ((B_WIDTH + 7) / 8) * 8;
  localparam int OUTP = ((OUT_WIDTH + 7) / 8) * 8;
  logic [2*AP-1:0]   s_axis_a_tdata;
  logic              s_axis_a_tuser;
  logic              s_axis_a_tlast;
  logic              s_axis_a_tvalid;
  logic              s_axis_a_tready;
  logic [2*BP-1:0]   s_axis_b_tdata;
  logic              s_axis_b_tvalid;
  logic              s_axis_b_tready;
  logic [2*OUTP-1:0] m_axis_dout_tdata;
  logic [1:0]        m_axis_dout_tuser;
  logic              m_axis_dout_tlast;
  logic              m_axis_dout_tvalid;
  logic              m_axis_dout_tready;
  logic [15:0]       ovf_count;
  logic              ovf_clear;
  modport master (
    output s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tlast, s_axis_a_tvalid,
    output s_axis_b_tdata, s_axis_b_tvalid, m_axis_dout_tready, ovf_clear,
    input  s_axis_a_tready, s_axis_b_tready, m_axis_dout_tdata, m_axis_dout_tuser,
    input  m_axis_dout_tlast, m_axis_dout_tvalid, ovf_count
  );
  modport slave (
    input  s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tlast, s_axis_a_tvalid,
    input  s_axis_b_tdata, s_axis_b_tvalid, m_axis_dout_tready, ovf_clear,
    output s_axis_a_tready, s_axis_b_tready, m_axis_dout_tdata, m_axis_dout_tuser,
    output m_axis_dout_tlast, m_axis_dout_tvalid, ovf_count
  );
endinterface

// File: rtl/complex_mac_stream.sv
// complex_mac_stream: pipelined complex multiply (optional conj(B)) with rounding, saturation and overflow count
module complex_mac_stream #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int STAGES     = 6,
  parameter int ROUND_MODE = 0,
  parameter int SATURATE   = 1
) (
  input logic aclk,
  input logic areset,
  complex_mac_stream_if.slave bus
);
  localparam int AP   = ((A_WIDTH + 7) / 8) * 8;
  localparam int BP   = ((B_WIDTH + 7) / 8) * 8;
  localparam int OUTP = ((OUT_WIDTH + 7) / 8) * 8;
  localparam int P    = A_WIDTH + B_WIDTH;
  localparam int W    = P + 2;
  localparam int CW   = ((W + 1 > OUT_WIDTH) ? W + 1 : OUT_WIDTH) + 1;
  localparam int N    = STAGES - 4;
  localparam logic signed [W:0]    HALF = ((W + 1)'(1) << SHIFT) >> 1;
  localparam logic        [W:0]    MASK = ((W + 1)'(1) << SHIFT) - (W + 1)'(1);
  localparam logic signed [CW-1:0] MAXV = (CW'(1) << (OUT_WIDTH - 1)) - CW'(1);
  localparam logic signed [CW-1:0] MINV = -MAXV - CW'(1);

  logic en, acc, hs;
  logic [4:0] v_q, lst_q;
  logic [1:0] cj_q;
  logic signed [A_WIDTH-1:0] ar_q, ai_q;
  logic signed [B_WIDTH-1:0] br_q, bi_q;
  logic signed [P-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [W-1:0] pr_q, pi_q;
  logic signed [W:0] rdr_q, rdi_q;
  logic [OUTP:0] sr_q, si_q;
  logic [N-1:0] dv_q, dl_q;
  logic [N-1:0][1:0] du_q;
  logic [N-1:0][2*OUTP-1:0] dd_q;
  logic [15:0] ovf_cnt_q;

  function automatic logic signed [W:0] rnd(input logic signed [W-1:0] v);
    logic signed [W:0] x, t, u;
    x = (W + 1)'(v);
    t = x >>> SHIFT;
    u = (x + HALF) >>> SHIFT;
    return (ROUND_MODE == 0) ? t : (ROUND_MODE == 2 && (x & MASK) == HALF && !t[0]) ? t : u;
  endfunction

  function automatic logic [OUTP:0] sat(input logic signed [W:0] r);
    logic signed [CW-1:0] e;
    logic signed [OUT_WIDTH-1:0] o;
    logic ovf;
    e = CW'(r);
    ovf = e > MAXV || e < MINV;
    o = (SATURATE != 0 && ovf) ? OUT_WIDTH'(e < 0 ? MINV : MAXV) : OUT_WIDTH'(e);
    return {ovf, OUTP'(o)};
  endfunction

  assign en  = !dv_q[N-1] || bus.m_axis_dout_tready;
  assign acc = bus.s_axis_a_tvalid && bus.s_axis_b_tvalid && en;
  assign hs  = dv_q[N-1] && bus.m_axis_dout_tready;
  assign bus.s_axis_a_tready    = en;
  assign bus.s_axis_b_tready    = en;
  assign bus.m_axis_dout_tvalid = dv_q[N-1];
  assign bus.m_axis_dout_tuser  = du_q[N-1];
  assign bus.m_axis_dout_tlast  = dl_q[N-1];
  assign bus.m_axis_dout_tdata  = dd_q[N-1];
  assign bus.ovf_count          = ovf_cnt_q;

  // Arithmetic pipe: capture, products, conj-aware sums, rounding, saturation
  always_ff @(posedge aclk)
    if (en) begin
      ar_q  <= $signed(bus.s_axis_a_tdata[A_WIDTH-1:0]);
      ai_q  <= $signed(bus.s_axis_a_tdata[AP+A_WIDTH-1:AP]);
      br_q  <= $signed(bus.s_axis_b_tdata[B_WIDTH-1:0]);
      bi_q  <= $signed(bus.s_axis_b_tdata[BP+B_WIDTH-1:BP]);
      cj_q  <= {cj_q[0], bus.s_axis_a_tuser};
      lst_q <= {lst_q[3:0], bus.s_axis_a_tlast};
      rr_q  <= P'(ar_q) * P'(br_q);
      ii_q  <= P'(ai_q) * P'(bi_q);
      ri_q  <= P'(ar_q) * P'(bi_q);
      ir_q  <= P'(ai_q) * P'(br_q);
      pr_q  <= cj_q[1] ? W'(rr_q) + W'(ii_q) : W'(rr_q) - W'(ii_q);
      pi_q  <= cj_q[1] ? W'(ir_q) - W'(ri_q) : W'(ri_q) + W'(ir_q);
      rdr_q <= rnd(pr_q);
      rdi_q <= rnd(pi_q);
      sr_q  <= sat(rdr_q);
      si_q  <= sat(rdi_q);
    end

  // Valid tracking and output delay line; flags of bubbles are forced to zero
  always_ff @(posedge aclk)
    if (areset) begin
      v_q  <= '0;
      dv_q <= '0;
      dl_q <= '0;
      du_q <= '0;
      dd_q <= '0;
    end else if (en) begin
      v_q  <= {v_q[3:0], acc};
      dv_q <= {dv_q[N-2:0], v_q[4]};
      dl_q <= {dl_q[N-2:0], lst_q[4]};
      du_q <= {du_q[N-2:0], {2{v_q[4]}} & {si_q[OUTP], sr_q[OUTP]}};
      dd_q <= {dd_q[N-2:0], si_q[OUTP-1:0], sr_q[OUTP-1:0]};
    end

  // Overflow beat counter, sticky at all-ones, clear wins over increment
  always_ff @(posedge aclk)
    if (areset || bus.ovf_clear) ovf_cnt_q <= '0;
    else if (hs && |du_q[N-1] && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
endmodule

// File: tb/tb_complex_mac_stream.sv
// tb_complex_mac_stream: directed and streaming checks over several rounding/saturation configurations
module tb_complex_mac_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_user = 1'b0, a_last = 1'b0, a_valid = 1'b0, b_valid = 1'b0, rdy = 1'b1, clr = 1'b0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  complex_mac_stream_if #(.OUT_WIDTH(33)) i_s0 ();
  assign i_s0.s_axis_a_tdata     = a_data;
  assign i_s0.s_axis_a_tuser     = a_user;
  assign i_s0.s_axis_a_tlast     = a_last;
  assign i_s0.s_axis_a_tvalid    = a_valid;
  assign i_s0.s_axis_b_tdata     = b_data;
  assign i_s0.s_axis_b_tvalid    = b_valid;
  assign i_s0.m_axis_dout_tready = rdy;
  assign i_s0.ovf_clear          = clr;
  complex_mac_stream #(.OUT_WIDTH(33), .SHIFT(0)) u_s0 (.aclk(clk), .areset(rst), .bus(i_s0));

  for (genvar g = 0; g < 4; g++) begin : g_m
    complex_mac_stream_if ifc ();
    assign ifc.s_axis_a_tdata     = a_data;
    assign ifc.s_axis_a_tuser     = a_user;
    assign ifc.s_axis_a_tlast     = a_last;
    assign ifc.s_axis_a_tvalid    = a_valid;
    assign ifc.s_axis_b_tdata     = b_data;
    assign ifc.s_axis_b_tvalid    = b_valid;
    assign ifc.m_axis_dout_tready = rdy;
    assign ifc.ovf_clear          = clr;
    complex_mac_stream #(.ROUND_MODE(g == 3 ? 0 : g), .SATURATE(g == 3 ? 0 : 1))
      u_dut (.aclk(clk), .areset(rst), .bus(ifc));
  end

  task automatic drive(input int ar, ai, br, bi, input logic cj, lst);
    a_data  = {16'(ai), 16'(ar)};
    b_data  = {16'(bi), 16'(br)};
    a_user  = cj;
    a_last  = lst;
    a_valid = 1'b1;
    b_valid = 1'b1;
  endtask

  task automatic idle;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic send(input int ar, ai, br, bi, input logic cj, lst, output logic ok);
    logic rd;
    drive(ar, ai, br, bi, cj, lst);
    #1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      rd = g_m[0].ifc.s_axis_a_tready;
      @(posedge clk);
      #1;
      ok = rd;
    end
    idle();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!g_m[0].ifc.m_axis_dout_tvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [15:0] mdl(input longint p);
    longint s;
    s = p >>> 15;
    s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    return 16'(s);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (g_m[0].ifc.m_axis_dout_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", g_m[0].ifc.m_axis_dout_tvalid); end
    n_vec++; if (g_m[0].ifc.m_axis_dout_tuser !== 2'b00) begin n_err++; $display("FAIL rst_tuser: got %b expected 00", g_m[0].ifc.m_axis_dout_tuser); end
    n_vec++; if (g_m[0].ifc.m_axis_dout_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b expected 0", g_m[0].ifc.m_axis_dout_tlast); end
    n_vec++; if (g_m[0].ifc.m_axis_dout_tdata !== 32'h0) begin n_err++; $display("FAIL rst_tdata: got %h expected 0", g_m[0].ifc.m_axis_dout_tdata); end
    n_vec++; if (i_s0.m_axis_dout_tdata !== 80'h0) begin n_err++; $display("FAIL rst_tdata_s0: got %h expected 0", i_s0.m_axis_dout_tdata); end
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'h0) begin n_err++; $display("FAIL rst_ovf: got %h expected 0", g_m[0].ifc.ovf_count); end
    n_vec++; if ({g_m[0].ifc.s_axis_a_tready, g_m[0].ifc.s_axis_b_tready} !== 2'b11) begin n_err++; $display("FAIL rst_tready: got %b expected 11", {g_m[0].ifc.s_axis_a_tready, g_m[0].ifc.s_axis_b_tready}); end
    rst = 1'b0;
  endtask

  task automatic test_full_precision;
    logic ok;
    int n;
    logic [79:0] e;
    send(1, 2, 3, 4, 1'b0, 1'b1, ok);
    wait_out(n);
    e = {40'(10), 40'(-5)};
    n_vec++; if (!ok || n != 6) begin n_err++; $display("FAIL fp_latency: got %0d cycles (accepted %b) expected 6", n, ok); end
    n_vec++; if (i_s0.m_axis_dout_tvalid !== 1'b1) begin n_err++; $display("FAIL fp_tvalid: got %b expected 1", i_s0.m_axis_dout_tvalid); end
    n_vec++; if (i_s0.m_axis_dout_tdata !== e) begin n_err++; $display("FAIL fp_conj0: got %h expected %h", i_s0.m_axis_dout_tdata, e); end
    n_vec++; if ({i_s0.m_axis_dout_tlast, i_s0.m_axis_dout_tuser} !== 3'b100) begin n_err++; $display("FAIL fp_last_user0: got %b expected 100", {i_s0.m_axis_dout_tlast, i_s0.m_axis_dout_tuser}); end
    send(1, 2, 3, 4, 1'b1, 1'b0, ok);
    wait_out(n);
    e = {40'(2), 40'(11)};
    n_vec++; if (!ok || n != 6) begin n_err++; $display("FAIL fp_latency_conj: got %0d cycles (accepted %b) expected 6", n, ok); end
    n_vec++; if (i_s0.m_axis_dout_tdata !== e) begin n_err++; $display("FAIL fp_conj1: got %h expected %h", i_s0.m_axis_dout_tdata, e); end
    n_vec++; if (i_s0.m_axis_dout_tlast !== 1'b0) begin n_err++; $display("FAIL fp_last1: got %b expected 0", i_s0.m_axis_dout_tlast); end
  endtask

  task automatic test_rounding;
    int av[3] = '{3, 5, -5};
    int ex[3][3] = '{'{1, 2, 2}, '{2, 3, 2}, '{-3, -2, -2}};
    logic ok;
    int n;
    logic signed [15:0] r0, r1, r2;
    for (int i = 0; i < 3; i++) begin
      send(av[i], 0, 16384, 0, 1'b0, 1'b0, ok);
      wait_out(n);
      r0 = g_m[0].ifc.m_axis_dout_tdata[15:0];
      r1 = g_m[1].ifc.m_axis_dout_tdata[15:0];
      r2 = g_m[2].ifc.m_axis_dout_tdata[15:0];
      n_vec++; if (!ok || n != 6) begin n_err++; $display("FAIL rnd_timing a=%0d: got %0d cycles expected 6", av[i], n); end
      n_vec++; if (r0 !== 16'(ex[i][0])) begin n_err++; $display("FAIL rnd_floor a=%0d: got %0d expected %0d", av[i], r0, ex[i][0]); end
      n_vec++; if (r1 !== 16'(ex[i][1])) begin n_err++; $display("FAIL rnd_halfup a=%0d: got %0d expected %0d", av[i], r1, ex[i][1]); end
      n_vec++; if (r2 !== 16'(ex[i][2])) begin n_err++; $display("FAIL rnd_conv a=%0d: got %0d expected %0d", av[i], r2, ex[i][2]); end
    end
  endtask

  task automatic test_overflow;
    logic ok;
    int n;
    send(-32768, -32768, -32768, 32767, 1'b0, 1'b0, ok);
    wait_out(n);
    n_vec++; if (g_m[0].ifc.m_axis_dout_tdata !== {16'd1, 16'h7FFF}) begin n_err++; $display("FAIL ovf_sat_data: got %h expected 00017fff", g_m[0].ifc.m_axis_dout_tdata); end
    n_vec++; if (g_m[0].ifc.m_axis_dout_tuser !== 2'b01) begin n_err++; $display("FAIL ovf_sat_user: got %b expected 01", g_m[0].ifc.m_axis_dout_tuser); end
    n_vec++; if (g_m[3].ifc.m_axis_dout_tdata !== {16'd1, 16'hFFFF}) begin n_err++; $display("FAIL ovf_wrap_data: got %h expected 0001ffff", g_m[3].ifc.m_axis_dout_tdata); end
    n_vec++; if (g_m[3].ifc.m_axis_dout_tuser !== 2'b01) begin n_err++; $display("FAIL ovf_wrap_user: got %b expected 01", g_m[3].ifc.m_axis_dout_tuser); end
    @(posedge clk);
    #1;
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'd1) begin n_err++; $display("FAIL ovf_cnt_sat: got %0d expected 1", g_m[0].ifc.ovf_count); end
    n_vec++; if (g_m[3].ifc.ovf_count !== 16'd1) begin n_err++; $display("FAIL ovf_cnt_wrap: got %0d expected 1", g_m[3].ifc.ovf_count); end
  endtask

  task automatic test_back_to_back;
    logic [34:0] q[$];
    logic [34:0] held, got, e;
    logic hs, acc, stall, lst, cj;
    int idx = 0, nrx = 0, cyc = 0;
    int ar, ai, br, bi;
    longint pr, pim;
    stall = 1'b0;
    held = '0;
    ar = int'($urandom_range(32766)) - 16383; ai = int'($urandom_range(32766)) - 16383;
    br = int'($urandom_range(32766)) - 16383; bi = int'($urandom_range(32766)) - 16383;
    cj = 1'($urandom); lst = 1'($urandom);
    while ((idx < 64 || nrx < 64) && cyc < 3000) begin
      if (idx < 64) begin
        drive(ar, ai, br, bi, cj, lst);
        a_valid = 1'($urandom);
        b_valid = 1'($urandom);
      end else idle();
      rdy = 1'($urandom);
      #1;
      got = {g_m[0].ifc.m_axis_dout_tlast, g_m[0].ifc.m_axis_dout_tuser, g_m[0].ifc.m_axis_dout_tdata};
      n_vec++; if (stall && (g_m[0].ifc.m_axis_dout_tvalid !== 1'b1 || got !== held)) begin n_err++; $display("FAIL b2b_stall_hold: got v=%b %h expected v=1 %h", g_m[0].ifc.m_axis_dout_tvalid, got, held); end
      acc = a_valid && b_valid && g_m[0].ifc.s_axis_a_tready;
      hs = g_m[0].ifc.m_axis_dout_tvalid && rdy;
      stall = g_m[0].ifc.m_axis_dout_tvalid && !rdy;
      held = got;
      @(posedge clk);
      #1;
      if (acc) begin
        pr  = cj ? longint'(ar) * br + longint'(ai) * bi : longint'(ar) * br - longint'(ai) * bi;
        pim = cj ? longint'(ai) * br - longint'(ar) * bi : longint'(ar) * bi + longint'(ai) * br;
        q.push_back({lst, 2'b00, mdl(pim), mdl(pr)});
        idx++;
        ar = int'($urandom_range(32766)) - 16383; ai = int'($urandom_range(32766)) - 16383;
        br = int'($urandom_range(32766)) - 16383; bi = int'($urandom_range(32766)) - 16383;
        cj = 1'($urandom); lst = 1'($urandom);
      end
      if (hs) begin
        e = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        n_vec++; if (got !== e) begin n_err++; $display("FAIL b2b_beat%0d: got %h expected %h", nrx, got, e); end
        nrx++;
      end
      cyc++;
    end
    n_vec++; if (nrx != 64 || q.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d beats (%0d pending) expected 64", nrx, q.size()); end
    idle();
    rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_flush;
    logic ok, seen;
    int n;
    logic signed [15:0] r;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(200 + i, 0, 16384, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    drive(300, 0, 16384, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'h0) begin n_err++; $display("FAIL flush_ovf: got %0d expected 0", g_m[0].ifc.ovf_count); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | g_m[0].ifc.m_axis_dout_tvalid;
      @(posedge clk);
      #1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_output: got tvalid seen=%b expected 0", seen); end
    send(100, 0, 16384, 0, 1'b0, 1'b1, ok);
    wait_out(n);
    r = g_m[0].ifc.m_axis_dout_tdata[15:0];
    n_vec++; if (!ok || n != 6) begin n_err++; $display("FAIL flush_latency: got %0d cycles expected 6", n); end
    n_vec++; if (r !== 16'sd50 || g_m[0].ifc.m_axis_dout_tlast !== 1'b1) begin n_err++; $display("FAIL flush_beat: got %0d last=%b expected 50 last=1", r, g_m[0].ifc.m_axis_dout_tlast); end
  endtask

  task automatic test_ovf_saturate;
    int cyc = 0;
    rdy = 1'b1;
    drive(-32768, -32768, -32768, 32767, 1'b0, 1'b0);
    while (g_m[0].ifc.ovf_count !== 16'hFFFF && cyc < 70000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach: got %h expected ffff", g_m[0].ifc.ovf_count); end
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h expected ffff", g_m[0].ifc.ovf_count); end
    n_vec++; if (g_m[3].ifc.ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold_wrap: got %h expected ffff", g_m[3].ifc.ovf_count); end
    n_vec++; if (!(g_m[0].ifc.m_axis_dout_tvalid === 1'b1 && g_m[0].ifc.m_axis_dout_tuser === 2'b01)) begin n_err++; $display("FAIL sat_pending_hs: got v=%b u=%b expected v=1 u=01", g_m[0].ifc.m_axis_dout_tvalid, g_m[0].ifc.m_axis_dout_tuser); end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    n_vec++; if (g_m[0].ifc.ovf_count !== 16'h0) begin n_err++; $display("FAIL clr_priority: got %h expected 0", g_m[0].ifc.ovf_count); end
    idle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_full_precision();
    test_rounding();
    test_overflow();
    test_back_to_back();
    test_reset_flush();
    test_ovf_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/complex_mac_stream.md
COMPLEX_MAC_STREAM -- requirements
Module: complex_mac_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- A_WIDTH, 16, signed width of each A component (real/imag), 2..32.
- B_WIDTH, 16, signed width of each B component, 2..32.
- OUT_WIDTH, 16, signed width of each output component, 2..48.
- SHIFT, 15, right-shift applied to the full-precision result, 0..A_WIDTH+B_WIDTH.
- STAGES, 6, pipeline latency in cycles, minimum 6.
- ROUND_MODE, 0, rounding: 0 floor, 1 round-half-up, 2 convergent (half-to-even).
- SATURATE, 1, 1 clamps on overflow, 0 wraps.
REQ-002 Field padding: XP = ((X_WIDTH+7)/8)*8 for A, B and OUT; real at [X_WIDTH-1:0], imag at [XP+X_WIDTH-1:XP].
REQ-003 Ports (name, direction, width, meaning), one per line:
- aclk, in, 1, clock; all logic on its rising edge.
- areset, in, 1, synchronous active-high reset.
- s_axis_a_tdata, in, 2*AP, operand A.
- s_axis_a_tuser, in, 1, 1 = multiply by conj(B).
- s_axis_a_tlast, in, 1, passed to output.
- s_axis_a_tvalid, in, 1, A valid.
- s_axis_a_tready, out, 1, A accepted.
- s_axis_b_tdata, in, 2*BP, operand B.
- s_axis_b_tvalid, in, 1, B valid.
- s_axis_b_tready, out, 1, B accepted.
- m_axis_dout_tdata, out, 2*OUTP, result; padding bits sign-extended.
- m_axis_dout_tuser, out, 2, {imag overflow, real overflow}.
- m_axis_dout_tlast, out, 1, delayed s_axis_a_tlast.
- m_axis_dout_tvalid, out, 1, result valid.
- m_axis_dout_tready, in, 1, downstream ready.
- ovf_count, out, 16, count of beats with any overflow, saturating at 0xFFFF.
- ovf_clear, in, 1, zero ovf_count.

Function
REQ-004 Pipeline enable en = !m_axis_dout_tvalid || m_axis_dout_tready; all stages, including valid, user and last shadows, advance only when en=1.
REQ-005 s_axis_a_tready = s_axis_b_tready = en (combinational); a beat is consumed only when both tvalids are 1 and en=1 (joint handshake); a lone valid is not consumed.
REQ-006 No beat is dropped or duplicated under any m_axis_dout_tready pattern; m_axis_dout_tdata/tuser/tlast are held stable while tvalid=1 and tready=0.
REQ-007 Latency: a beat consumed at edge k is presented with m_axis_dout_tvalid=1 after edge k+STAGES when en stays 1; each stall cycle adds exactly one cycle; throughput is 1 beat/cycle.
REQ-008 Arithmetic, full precision (A_WIDTH+B_WIDTH+2 bits): conj=0 gives p_r = ar*br - ai*bi and p_i = ar*bi + ai*br; conj=1 gives p_r = ar*br + ai*bi and p_i = ai*br - ar*bi.
REQ-009 Rounding of each component by SHIFT:
- Mode 0: arithmetic shift (floor).
- Mode 1: add 2^(SHIFT-1), then shift.
- Mode 2: as mode 1, except an exact half with an even truncated result rounds down.
- SHIFT=0: the value passes unrounded.
REQ-010 Overflow is set when the rounded value lies outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- SATURATE=1: clamp to the nearest limit.
- SATURATE=0: keep the low OUT_WIDTH bits.
- The flag goes to the corresponding m_axis_dout_tuser bit in both cases.
REQ-011 ovf_count increments by 1 per output handshake (tvalid&tready) with any tuser bit set; it holds at 0xFFFF; ovf_clear takes priority over an increment in the same cycle.
REQ-012 tuser (conj) and tlast travel with their beat through all STAGES.

Reset
REQ-013 While areset=1 on an edge:
- Cleared: m_axis_dout_tvalid, all internal valids, m_axis_dout_tuser, m_axis_dout_tlast, ovf_count.
- m_axis_dout_tdata is cleared to 0.
- Data registers need no reset.
REQ-014 s_axis_*_tready is 1 during reset (en=1 because tvalid=0), but beats presented during reset are discarded; in-flight beats at reset assertion are lost; the first post-reset output is the first beat accepted after reset deassertion.

Verification
REQ-015 Bench uses A=B=OUT=16, SHIFT=15 unless stated and covers:
- SHIFT=0, OUT_WIDTH=33, a=(1,2), b=(3,4), conj=0 -> (-5,10); conj=1 -> (11,2); tvalid exactly STAGES cycles after accept.
- a=(3,0), b=(16384,0) -> real 1 (mode 0), 2 (mode 1), 2 (mode 2); a=(5,0) -> 2/3/2; a=(-5,0) -> -3/-2/-2.
- a=(-32768,-32768), b=(-32768,32767), SATURATE=1 -> (32767,1), tuser=2'b01, ovf_count +1; SATURATE=0 -> real -1, same flag.
- Back-to-back 64 beats with random tready (50%) and random independent A/B tvalid -> output sequence equals model, tlast preserved, data stable during stalls.
- areset pulsed 1 cycle with 3 beats in flight -> no output for them; next accepted beat appears STAGES cycles later; ovf_count=0.
- ovf_count preloaded to 0xFFFF via overflow beats -> stays 0xFFFF; ovf_clear coincident with an overflow handshake -> 0.
